alu_decrement: RTL
==================

# alu_decrement

Sequential decrement unit for the ALU datapath, the counterpart of the single-step incrementer. It accepts an operand and a step count over a valid/ready handshake, then decrements the operand once per clock for the requested number of steps. It presents the result with borrow and zero flags over a second valid/ready handshake. It sits between the ALU operand registers and the result writeback stage.

## Interface
- `WIDTH`, default 8: operand, step-count and result width in bits.

- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `in_valid`  input  1  operand/step pair offered.
- `in_ready`  output  1  unit can accept a new pair; high only in IDLE.
- `in_a`  input  WIDTH  operand to decrement.
- `in_steps`  input  WIDTH  number of single decrements to apply, 0..2^WIDTH-1.
- `out_valid`  output  1  result available; high only in DONE.
- `out_ready`  input  1  downstream consumes the result.
- `out_y`  output  WIDTH  decremented result.
- `out_borrow`  output  1  sticky flag: at least one decrement was applied while the accumulator was 0.
- `out_zero`  output  1  `out_y` equals 0.

## Operation
- States: IDLE, COUNT, DONE.
- Reset values: state IDLE, `out_y` 0, `out_borrow` 0, `out_zero` 0, `out_valid` 0, `in_ready` 1. Internal accumulator and remaining-step counter reset to 0.
- **IDLE:**
  - On `in_valid && in_ready`, load the accumulator from `in_a`, load the remaining counter from `in_steps`, and clear borrow.
  - Next state is COUNT if `in_steps != 0`, otherwise DONE.
- **COUNT:**
  - Each cycle, accumulator <= accumulator − 1 modulo 2^WIDTH, and remaining <= remaining − 1.
  - If the accumulator is 0 before the step, set borrow.
  - When remaining equals 1 before the step, the next state is DONE.
- **DONE:**
  - `out_y`, `out_borrow` and `out_zero` are registered and stay stable while `out_valid` is high.
  - On `out_ready`, the next state is IDLE.
- `in_valid` outside IDLE is ignored; no input is queued.
- Arithmetic is unsigned, WIDTH bits, with no overflow other than the borrow at 0.
- Reset asserted in any state forces the reset values at that edge and aborts any operation in progress. The pending result is discarded.

## Timing
- Accept at edge k. The unit then spends `in_steps` cycles in COUNT, and `out_valid` is high from edge k+`in_steps`+1.
- With `in_steps` = 0, `out_valid` is high from edge k+1.
- A result is consumed at the edge where `out_valid && out_ready` are both high. `in_ready` rises at the following edge, which gives one IDLE cycle per operation at minimum.
- All outputs are registered; there is no combinational path from an input to an output.

## Configuration
- `ALU_DEC_SATURATE_EN`
  - **Defined:** a decrement with accumulator 0 leaves it at 0. Borrow is still set.
  - **Undefined:** the accumulator wraps to 2^WIDTH−1, and borrow is set.

## Structure
- Package `alu_dec_pkg` holds:
  - the state enum typedef `dec_state_t` (IDLE, COUNT, DONE);
  - the default width constant `ALU_DEC_WIDTH = 8`.
- One combinational sub-module, `alu_dec_step`:
  - inputs: value, saturate enable;
  - outputs: value−1, borrow.
  - It is instantiated once for the accumulator path.

## Test plan
All scenarios use WIDTH = 8.
- Reset held 2 cycles → `in_ready`=1, `out_valid`=0, `out_y`=0x00, `out_borrow`=0, `out_zero`=0.
- `in_a`=0x05, `in_steps`=3, `out_ready`=1 → `out_valid` at accept+4 cycles; `out_y`=0x02, `out_borrow`=0, `out_zero`=0.
- `in_a`=0x01, `in_steps`=2:
  - without the macro → `out_y`=0xFF, `out_borrow`=1, `out_zero`=0;
  - with `ALU_DEC_SATURATE_EN` → `out_y`=0x00, `out_borrow`=1, `out_zero`=1.
- `in_a`=0x80, `in_steps`=0 → `out_valid` at accept+1, `out_y`=0x80, `out_borrow`=0.
- `in_a`=0x10, `in_steps`=1, `out_ready` low for 3 cycles in DONE:
  - while stalled → `out_y`=0x0F held stable, `in_ready`=0, and a second `in_valid` is ignored;
  - after `out_ready`=1 → `in_ready`=1 at the next edge.
- `in_a`=0x20, `in_steps`=10, `rst_n` low at the 4th COUNT cycle → IDLE with reset values at that edge; no `out_valid` pulse follows.

Source files
------------

// File: rtl/alu_dec_pkg.sv
// Shared types and constants for the sequential decrement unit.
package alu_dec_pkg;

  localparam int ALU_DEC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } dec_state_t;

endpackage

// File: rtl/alu_dec_step.sv
// Single-step decrementer: value-1 with borrow at zero, optionally clamped at zero.
module alu_dec_step
  import alu_dec_pkg::*;
#(
  parameter int WIDTH = ALU_DEC_WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             sat_en_i,
  output logic [WIDTH-1:0] value_o,
  output logic             borrow_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Borrow whenever we step down from zero; saturation only changes the value.
  always_comb begin
    borrow_o = (value_i == '0);
    if (borrow_o && sat_en_i) value_o = '0;
    else                      value_o = value_i - ONE;
  end

endmodule

// File: rtl/alu_decrement.sv
// Sequential decrement unit: accepts (operand, steps), decrements once per
// clock, then holds the result with borrow/zero flags until consumed.
// Build option: ALU_DEC_SATURATE_EN clamps the accumulator at zero instead of
// wrapping (borrow is reported either way).
//
//   state | meaning
//   IDLE  | waiting for an operand/step pair, in_ready high
//   COUNT | applying one decrement per cycle until remaining reaches zero
//   DONE  | result registered and presented, out_valid high until out_ready
module alu_decrement
  import alu_dec_pkg::*;
#(
  parameter int WIDTH = ALU_DEC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_steps,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_borrow,
  output logic             out_zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef ALU_DEC_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  dec_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             oborrow_q, oborrow_d;
  logic             ozero_q, ozero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] step_y;
  logic             step_b;

  alu_dec_step #(.WIDTH(WIDTH)) u_step (
    .value_i  (acc_q),
    .sat_en_i (SAT_EN),
    .value_o  (step_y),
    .borrow_o (step_b)
  );

  // Next-state and datapath updates; result registers load only on entry to DONE.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    borrow_d  = borrow_q;
    y_d       = y_q;
    oborrow_d = oborrow_q;
    ozero_d   = ozero_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          acc_d    = in_a;
          rem_d    = in_steps;
          borrow_d = 1'b0;
          if (in_steps != '0) begin
            state_d = COUNT;
          end else begin
            state_d   = DONE;
            y_d       = in_a;
            oborrow_d = 1'b0;
            ozero_d   = (in_a == '0);
          end
        end
      end
      COUNT: begin
        acc_d    = step_y;
        rem_d    = rem_q - ONE;
        borrow_d = borrow_q | step_b;
        if (rem_q == ONE) begin
          state_d   = DONE;
          y_d       = step_y;
          oborrow_d = borrow_q | step_b;
          ozero_d   = (step_y == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered from the next state so they never see inputs combinationally.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      borrow_q    <= 1'b0;
      y_q         <= '0;
      oborrow_q   <= 1'b0;
      ozero_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      borrow_q    <= borrow_d;
      y_q         <= y_d;
      oborrow_q   <= oborrow_d;
      ozero_q     <= ozero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_y      = y_q;
  assign out_borrow = oborrow_q;
  assign out_zero   = ozero_q;

endmodule
